// File: rtl/mouse_tracker.sv
// Cursor tracker: turns decoded PS/2 mouse packets into a clamped absolute position,
// latches button presses until acknowledged and queues position snapshots in an event FIFO.
module mouse_tracker #(
    parameter int unsigned WIDTH       = 1280,
    parameter int unsigned HEIGHT      = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter bit          INVERT_Y    = 1'b1,
    localparam int unsigned X_W        = $clog2(WIDTH),
    localparam int unsigned Y_W        = $clog2(HEIGHT)
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           pkt_valid_i,
    input  logic [8:0]     pkt_dx_i,
    input  logic [8:0]     pkt_dy_i,
    input  logic [2:0]     pkt_btn_i,
    input  logic           pkt_xov_i,
    input  logic           pkt_yov_i,
    input  logic           set_valid_i,
    input  logic [X_W-1:0] set_x_i,
    input  logic [Y_W-1:0] set_y_i,
    input  logic           ack_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic [2:0]     btn_o,
    output logic [2:0]     btn_sticky_o,
    output logic           evt_valid_o,
    input  logic           evt_ready_i,
    output logic [X_W-1:0] evt_x_o,
    output logic [Y_W-1:0] evt_y_o,
    output logic [2:0]     evt_btn_o,
    output logic           evt_overflow_o,
    output logic           irq_o
);

    localparam int unsigned DW = 13;
    localparam int unsigned SW = ((X_W > Y_W) ? X_W : Y_W) + 3;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = X_W + Y_W + 3;
    localparam logic signed [SW-1:0] XMAX = SW'(WIDTH - 1);
    localparam logic signed [SW-1:0] YMAX = SW'(HEIGHT - 1);

    // An overflowed axis saturates to full-scale in the direction of the raw delta.
    function automatic logic signed [DW-1:0] scale_delta(input logic [8:0] raw, input logic ovf);
        logic signed [DW-1:0] mag;
        mag = ovf ? (raw[8] ? -13'sd255 : 13'sd255) : DW'($signed(raw));
        return mag <<< SCALE_SHIFT;
    endfunction

    logic                 s1_valid_q;
    logic signed [DW-1:0] s1_dx_q, s1_dy_q;
    logic [2:0]           s1_btn_q;
    logic signed [DW-1:0] dy_scaled;

    always_comb begin
        dy_scaled = scale_delta(pkt_dy_i, pkt_yov_i);
        if (INVERT_Y) dy_scaled = -dy_scaled;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_btn_q   <= '0;
        end else begin
            s1_valid_q <= pkt_valid_i;
            if (pkt_valid_i) begin
                s1_dx_q  <= scale_delta(pkt_dx_i, pkt_xov_i);
                s1_dy_q  <= dy_scaled;
                s1_btn_q <= pkt_btn_i;
            end
        end
    end

    logic [X_W-1:0]       x_q, x_d, x_sum_clamped, x_warp;
    logic [Y_W-1:0]       y_q, y_d, y_sum_clamped, y_warp;
    logic [2:0]           btn_q, btn_d, sticky_q, sticky_d;
    logic signed [SW-1:0] sum_x, sum_y;
    logic                 push;

    always_comb begin
        sum_x = $signed(SW'(x_q)) + SW'(s1_dx_q);
        sum_y = $signed(SW'(y_q)) + SW'(s1_dy_q);
        if (sum_x < 0)         x_sum_clamped = '0;
        else if (sum_x > XMAX) x_sum_clamped = X_W'(WIDTH - 1);
        else                   x_sum_clamped = X_W'(sum_x);
        if (sum_y < 0)         y_sum_clamped = '0;
        else if (sum_y > YMAX) y_sum_clamped = Y_W'(HEIGHT - 1);
        else                   y_sum_clamped = Y_W'(sum_y);
        x_warp = ({1'b0, set_x_i} > (X_W + 1)'(WIDTH - 1))  ? X_W'(WIDTH - 1)  : set_x_i;
        y_warp = ({1'b0, set_y_i} > (Y_W + 1)'(HEIGHT - 1)) ? Y_W'(HEIGHT - 1) : set_y_i;
    end

    // Warp overrides the commit's position only; the commit's buttons and event still go through.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        btn_d    = btn_q;
        sticky_d = ack_i ? 3'b000 : sticky_q;
        push     = 1'b0;
        if (s1_valid_q) begin
            x_d      = x_sum_clamped;
            y_d      = y_sum_clamped;
            btn_d    = s1_btn_q;
            sticky_d = sticky_d | (s1_btn_q & ~btn_q);
            push     = 1'b1;
        end
        if (set_valid_i) begin
            x_d = x_warp;
            y_d = y_warp;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_q      <= X_W'(WIDTH / 2);
            y_q      <= Y_W'(HEIGHT / 2);
            btn_q    <= '0;
            sticky_q <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            btn_q    <= btn_d;
            sticky_q <= sticky_d;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push_ok, drop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = evt_ready_i & ~empty;
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;
        ovf_d   = drop ? 1'b1 : (ack_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {x_d, y_d, btn_d};
    end

    assign {evt_x_o, evt_y_o, evt_btn_o} = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid_o    = ~empty;
    assign evt_overflow_o = ovf_q;
    assign x_o            = x_q;
    assign y_o            = y_q;
    assign btn_o          = btn_q;
    assign btn_sticky_o   = sticky_q;
    assign irq_o          = ~empty | (|sticky_q);

endmodule
